// File: rtl/booth_pkg.sv
// ----------------------------------------------------------------------------
// booth_pkg
// Shared types for the Booth multiplier sequencer:
//   state_t  - sequencer FSM states
//   res_t    - result record {product, tag, err} at the default widths
// No ports (package).
// ----------------------------------------------------------------------------
package booth_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int TAG_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      WAIT    = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   typedef struct packed {
      logic [2*WIDTH_DEF-1:0] product;
      logic [TAG_W_DEF-1:0]   tag;
      logic                   err;
   } res_t;

endpackage

// File: rtl/booth_result_fifo.sv
// ----------------------------------------------------------------------------
// booth_result_fifo
// Pointer-based result FIFO. Full/empty are derived from an occupancy count.
// Push and pop in the same cycle leave the count unchanged; a pop frees the
// slot in the same cycle, so push on full is accepted when a pop coincides.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   push, push_data     write request and data
//   pop                 remove head (ignored when empty)
//   head                current head entry (0 after reset)
//   valid               FIFO not empty
//   full                FIFO holds DEPTH entries
// ----------------------------------------------------------------------------
module booth_result_fifo #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              valid,
   output logic              full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      do_pop  = pop && (count_q != '0);
      do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   assign head  = mem_q[rd_q];
   assign valid = (count_q != '0);
   assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/booth_mult_sequencer.sv
// ----------------------------------------------------------------------------
// booth_mult_sequencer
// Issues signed operand pairs to an external Booth multiplier and captures
// the product (or a timeout error) into a result FIFO with a sequence tag.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | multiplier held clear, accepting a pair when FIFO has room
// LOAD    | mul_load high with new operands for LOAD_CYCLES cycles
// WAIT    | multiplier running; wait for mul_done or TIMEOUT_CYCLES
// CAPTURE | push {product, tag, err} into the result FIFO
//
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   in_valid/in_ready                operand handshake
//   in_multiplicand, in_multiplier   signed operands
//   mul_load                         multiplier clear/load (high = clear)
//   mul_multiplicand, mul_multiplier registered operands to the multiplier
//   mul_product, mul_done            multiplier result and done level
//   res_valid/res_ready              result handshake (FIFO head)
//   res_product, res_tag, res_err    result fields
//   busy                             FSM not in IDLE
// ----------------------------------------------------------------------------
module booth_mult_sequencer
   import booth_pkg::*;
#(
   parameter int WIDTH          = WIDTH_DEF,
   parameter int RES_DEPTH      = 2,
   parameter int LOAD_CYCLES    = 1,
   parameter int TIMEOUT_CYCLES = 15,
   parameter int TAG_W          = TAG_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_multiplicand,
   input  logic [WIDTH-1:0]   in_multiplier,
   output logic               mul_load,
   output logic [WIDTH-1:0]   mul_multiplicand,
   output logic [WIDTH-1:0]   mul_multiplier,
   input  logic [2*WIDTH-1:0] mul_product,
   input  logic               mul_done,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_product,
   output logic [TAG_W-1:0]   res_tag,
   output logic               res_err,
   output logic               busy
);

   localparam int CNT_MAX = (LOAD_CYCLES > TIMEOUT_CYCLES) ? LOAD_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RES_W   = 2*WIDTH + TAG_W + 1;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [TAG_W-1:0]     tag_q, tag_d;
   logic [TAG_W-1:0]     cur_tag_q, cur_tag_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic                 err_q, err_d;
   logic                 live_q, live_d;
   logic                 fifo_full;
   logic                 push;
   logic                 accept;
   logic [RES_W-1:0]     push_data;
   logic [RES_W-1:0]     head;

   // live_q keeps in_ready low while reset is asserted and for the first
   // cycle after release.
   assign in_ready = live_q && (state_q == IDLE) && !fifo_full;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      tag_d     = tag_q;
      cur_tag_d = cur_tag_q;
      prod_d    = prod_q;
      err_d     = err_q;
      live_d    = 1'b1;
      push      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               mcand_d   = in_multiplicand;
               mplier_d  = in_multiplier;
               cur_tag_d = tag_q;
               tag_d     = tag_q + 1'b1;
               cnt_d     = CNT_W'(LOAD_CYCLES - 1);
               state_d   = LOAD;
            end
         end
         LOAD: begin
            if (cnt_q == '0) begin
               // cnt_q counts WAIT cycles from 1 so the timeout compare reads
               // directly as "this is WAIT cycle TIMEOUT_CYCLES".
               cnt_d   = CNT_W'(1);
               state_d = WAIT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WAIT: begin
            if (mul_done) begin
               prod_d  = mul_product;
               err_d   = 1'b0;
               state_d = CAPTURE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
               prod_d  = '0;
               err_d   = 1'b1;
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CAPTURE: begin
            // The slot was reserved at accept, so this push always lands.
            push    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         tag_q     <= '0;
         cur_tag_q <= '0;
         prod_q    <= '0;
         err_q     <= 1'b0;
         live_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         tag_q     <= tag_d;
         cur_tag_q <= cur_tag_d;
         prod_q    <= prod_d;
         err_q     <= err_d;
         live_q    <= live_d;
      end
   end

   assign mul_load         = (state_q != WAIT);
   assign mul_multiplicand = mcand_q;
   assign mul_multiplier   = mplier_q;
   assign busy             = (state_q != IDLE);
   assign push_data        = {prod_q, cur_tag_q, err_q};

   booth_result_fifo #(
      .DEPTH  (RES_DEPTH),
      .DATA_W (RES_W)
   ) u_res_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (res_valid && res_ready),
      .head      (head),
      .valid     (res_valid),
      .full      (fifo_full)
   );

   assign res_product = head[RES_W-1 -: 2*WIDTH];
   assign res_tag     = head[TAG_W:1];
   assign res_err     = head[0];

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// ----------------------------------------------------------------------------
// tb_booth_mult_sequencer
// Directed bench for booth_mult_sequencer with a behavioural multiplier whose
// latency (cycles after mul_load falls until mul_done) is set by mul_lat;
// mul_lat = 0 means the multiplier never finishes.
// ----------------------------------------------------------------------------
module tb_booth_mult_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_a = '0;
   logic [3:0] in_b = '0;
   logic       mul_load;
   logic [3:0] mul_a, mul_b;
   logic [7:0] mul_product = '0;
   logic       mul_done = 1'b0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_product;
   logic [3:0] res_tag;
   logic       res_err;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   int mul_lat = 4;
   int run_cnt = 0;
   int n_wait;

   always #5 clk = ~clk;

   booth_mult_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_multiplicand  (in_a),
      .in_multiplier    (in_b),
      .mul_load         (mul_load),
      .mul_multiplicand (mul_a),
      .mul_multiplier   (mul_b),
      .mul_product      (mul_product),
      .mul_done         (mul_done),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_product      (res_product),
      .res_tag          (res_tag),
      .res_err          (res_err),
      .busy             (busy)
   );

   function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
      logic signed [7:0] x, y;
      x = {{4{a[3]}}, a};
      y = {{4{b[3]}}, b};
      return x * y;
   endfunction

   always @(posedge clk) begin
      if (mul_load) begin
         run_cnt     <= 0;
         mul_done    <= 1'b0;
         mul_product <= '0;
      end else begin
         run_cnt <= run_cnt + 1;
         if (mul_lat != 0 && run_cnt + 1 == mul_lat) begin
            mul_done    <= 1'b1;
            mul_product <= smul(mul_a, mul_b);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Entered and left at a falling edge; returns just after the accept edge.
   task automatic do_op(input logic [3:0] a, input logic [3:0] b);
      int t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic expect_res(input string name, input logic [7:0] p,
                             input logic [3:0] tg, input logic e);
      int t = 0;
      while (!res_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      check({name, "_valid"},   32'(res_valid),   32'd1);
      check({name, "_product"}, 32'(res_product), 32'(p));
      check({name, "_tag"},     32'(res_tag),     32'(tg));
      check({name, "_err"},     32'(res_err),     32'(e));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   // Counts WAIT cycles (busy with mul_load low) until the FSM returns to IDLE.
   task automatic count_wait(output int n);
      int t = 0;
      n = 0;
      while (busy && t < 200) begin
         if (!mul_load) n++;
         @(negedge clk);
         t++;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset values
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mul_load",  32'(mul_load),    32'd1);
      check("rst_in_ready",  32'(in_ready),    32'd0);
      check("rst_res_valid", 32'(res_valid),   32'd0);
      check("rst_busy",      32'(busy),        32'd0);
      check("rst_product",   32'(res_product), 32'd0);
      check("rst_tag",       32'(res_tag),     32'd0);
      check("rst_err",       32'(res_err),     32'd0);
      check("rst_mcand",     32'(mul_a),       32'd0);
      check("rst_mplier",    32'(mul_b),       32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Single op 3 x 5
      mul_lat = 4;
      do_op(4'd3, 4'd5);
      check("load_busy",     32'(busy),     32'd1);
      check("load_mul_load", 32'(mul_load), 32'd1);
      check("load_mcand",    32'(mul_a),    32'd3);
      check("load_mplier",   32'(mul_b),    32'd5);
      @(negedge clk);
      check("wait_mul_load", 32'(mul_load), 32'd0);
      check("wait_mcand",    32'(mul_a),    32'd3);
      check("wait_mplier",   32'(mul_b),    32'd5);
      expect_res("op_3x5", 8'h0F, 4'd0, 1'b0);
      check("after_busy",      32'(busy),      32'd0);
      check("after_res_valid", 32'(res_valid), 32'd0);
      check("after_in_ready",  32'(in_ready),  32'd1);

      // Back-to-back pairs after a fresh reset
      pulse_reset();
      fork
         begin
            do_op(4'h8, 4'h8);
            do_op(4'h7, 4'hF);
            do_op(4'hD, 4'h4);
         end
         begin
            expect_res("b2b_m8xm8", 8'h40, 4'd0, 1'b0);
            expect_res("b2b_7xm1",  8'hF9, 4'd1, 1'b0);
            expect_res("b2b_m3x4",  8'hF4, 4'd2, 1'b0);
         end
      join

      // Backpressure: FIFO of two fills, third pair waits for a pop
      do_op(4'd2, 4'd3);
      do_op(4'hF, 4'hF);
      count_wait(n_wait);
      repeat (3) @(negedge clk);
      check("full_in_ready",  32'(in_ready),    32'd0);
      check("full_res_valid", 32'(res_valid),   32'd1);
      check("full_head_prod", 32'(res_product), 32'h06);
      check("full_head_tag",  32'(res_tag),     32'd3);
      expect_res("bp_2x3", 8'h06, 4'd3, 1'b0);
      check("pop_in_ready", 32'(in_ready), 32'd1);
      do_op(4'hC, 4'h2);
      expect_res("bp_m1xm1", 8'h01, 4'd4, 1'b0);
      expect_res("bp_m4x2",  8'hF8, 4'd5, 1'b0);

      // Timeout: multiplier never finishes
      mul_lat = 0;
      do_op(4'd5, 4'd5);
      count_wait(n_wait);
      check("timeout_wait_cycles", 32'(n_wait), 32'd15);
      expect_res("timeout", 8'h00, 4'd6, 1'b0 ^ 1'b1);

      // Done visible on WAIT cycle 15 wins over the timeout
      mul_lat = 14;
      do_op(4'd5, 4'd5);
      count_wait(n_wait);
      check("late_done_wait_cycles", 32'(n_wait), 32'd15);
      expect_res("late_done", 8'h19, 4'd7, 1'b0);

      // Done one cycle too late
      mul_lat = 15;
      do_op(4'hE, 4'd3);
      count_wait(n_wait);
      check("too_late_wait_cycles", 32'(n_wait), 32'd15);
      expect_res("too_late", 8'h00, 4'd8, 1'b1);

      // Reset asserted during WAIT
      mul_lat = 4;
      do_op(4'd1, 4'd1);
      @(negedge clk);
      check("pre_rst_mul_load", 32'(mul_load), 32'd0);
      reset = 1'b0;
      #1;
      check("midrst_mul_load",  32'(mul_load),  32'd1);
      check("midrst_res_valid", 32'(res_valid), 32'd0);
      check("midrst_busy",      32'(busy),      32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_op(4'd2, 4'd2);
      expect_res("post_rst", 8'h04, 4'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
